// File: rtl/decode_operand_stage.sv
// Decode-side operand fetch: register read, bypass/stall resolution, valid/ready output register.
// Define DECODE_BYPASS_EN for forwarding from EXE/MEM/WB; otherwise any in-flight producer stalls.
module decode_operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ADR_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             IF_VALID_SI,
    input  logic [XLEN-1:0]  IF_INSTR_SI,
    input  logic [XLEN-1:0]  IF_PC_SI,
    output logic             DEC_READY_SD,
    output logic [ADR_W-1:0] RADR1_SD,
    output logic [ADR_W-1:0] RADR2_SD,
    input  logic [XLEN-1:0]  RDATA1_SR,
    input  logic [XLEN-1:0]  RDATA2_SR,
    input  logic             EXE_VALID_SE,
    input  logic [ADR_W-1:0] EXE_RD_SE,
    input  logic [XLEN-1:0]  EXE_DATA_SE,
    input  logic             EXE_LOAD_SE,
    input  logic             MEM_VALID_SM,
    input  logic [ADR_W-1:0] MEM_RD_SM,
    input  logic [XLEN-1:0]  MEM_DATA_SM,
    input  logic             WENABLE_SW,
    input  logic [ADR_W-1:0] WADR_SW,
    input  logic [XLEN-1:0]  WDATA_SW,
    input  logic             FLUSH_SE,
    input  logic             EXE_READY_SE,
    output logic             DEC_VALID_SD,
    output logic [XLEN-1:0]  DEC_OP1_SD,
    output logic [XLEN-1:0]  DEC_OP2_SD,
    output logic [ADR_W-1:0] DEC_RD_SD,
    output logic [XLEN-1:0]  DEC_INSTR_SD,
    output logic [XLEN-1:0]  DEC_PC_SD
);

    localparam int unsigned PadW = ADR_W - 5;

    logic [ADR_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]  op1, op2;
    logic             hazard;
    logic             accept;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  op1_q, op2_q, instr_q, pc_q;
    logic [ADR_W-1:0] rd_q;

    assign rs1 = {{PadW{1'b0}}, IF_INSTR_SI[19:15]};
    assign rs2 = {{PadW{1'b0}}, IF_INSTR_SI[24:20]};
    assign rd  = {{PadW{1'b0}}, IF_INSTR_SI[11:7]};

    assign RADR1_SD = rs1;
    assign RADR2_SD = rs2;

    // x0 is never a real producer destination, so it never matches.
    function automatic logic match(input logic v, input logic [ADR_W-1:0] prod,
                                   input logic [ADR_W-1:0] rs);
        return v && (prod != '0) && (prod == rs);
    endfunction

`ifdef DECODE_BYPASS_EN
    function automatic logic [XLEN-1:0] resolve(input logic [ADR_W-1:0] rs,
                                                input logic [XLEN-1:0]  rdata);
        if (rs == '0)                              return '0;
        else if (match(EXE_VALID_SE, EXE_RD_SE, rs)) return EXE_DATA_SE;
        else if (match(MEM_VALID_SM, MEM_RD_SM, rs)) return MEM_DATA_SM;
        else if (match(WENABLE_SW, WADR_SW, rs))     return WDATA_SW;
        else                                       return rdata;
    endfunction

    // Only a load in EXE has no data yet; everything else is forwarded.
    assign hazard = EXE_VALID_SE && EXE_LOAD_SE &&
                    (match(1'b1, EXE_RD_SE, rs1) || match(1'b1, EXE_RD_SE, rs2));
`else
    function automatic logic [XLEN-1:0] resolve(input logic [ADR_W-1:0] rs,
                                                input logic [XLEN-1:0]  rdata);
        return (rs == '0) ? '0 : rdata;
    endfunction

    assign hazard = match(EXE_VALID_SE, EXE_RD_SE, rs1) || match(EXE_VALID_SE, EXE_RD_SE, rs2) ||
                    match(MEM_VALID_SM, MEM_RD_SM, rs1) || match(MEM_VALID_SM, MEM_RD_SM, rs2) ||
                    match(WENABLE_SW, WADR_SW, rs1)     || match(WENABLE_SW, WADR_SW, rs2);

    logic unused_fwd;
    assign unused_fwd = EXE_LOAD_SE ^ (^EXE_DATA_SE) ^ (^MEM_DATA_SM) ^ (^WDATA_SW);
`endif

    assign op1 = resolve(rs1, RDATA1_SR);
    assign op2 = resolve(rs2, RDATA2_SR);

    assign DEC_READY_SD = !FLUSH_SE && !hazard && (!valid_q || EXE_READY_SE);
    assign accept       = IF_VALID_SI && DEC_READY_SD;

    always_comb begin
        valid_d = valid_q;
        if (FLUSH_SE) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (EXE_READY_SE) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                op1_q   <= op1;
                op2_q   <= op2;
                rd_q    <= rd;
                instr_q <= IF_INSTR_SI;
                pc_q    <= IF_PC_SI;
            end
        end
    end

    assign DEC_VALID_SD = valid_q;
    assign DEC_OP1_SD   = op1_q;
    assign DEC_OP2_SD   = op2_q;
    assign DEC_RD_SD    = rd_q;
    assign DEC_INSTR_SD = instr_q;
    assign DEC_PC_SD    = pc_q;

endmodule
